// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: owns the PC, drives the instruction memory address and
// fills the IF/ID register under branch/flush/stall control until a halt word.
module instruction_fetch_unit #(
    parameter int              ADDR_W     = 16,
    parameter int              DATA_W     = 32,
    parameter int              MEM_DEPTH  = 256,
    parameter logic [15:0]     RESET_PC   = 16'h0001,
    parameter logic [31:0]     HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // MEM_DEPTH is a power of two, so wrapping is a simple mask.
    localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
    localparam logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_INSTR);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] ifpc_q, ifpc_d;
    logic              valid_q, valid_d;
    logic [15:0]       count_q, count_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d    = branch_target & PC_MASK;
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (flush) begin
                    valid_d = 1'b0;
                    instr_d = '0;
                end else if (!stall) begin
                    // read_data is only sampled here, so junk on a blocked cycle never lands.
                    instr_d = read_data;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    if (read_data == HALT_WORD) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d = (pc_q + ADDR_W'(1)) & PC_MASK;
                    end
                end
            end
            ST_HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            ifpc_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign inst_address = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifpc_q;
    assign if_id_valid  = valid_q;
    assign halted       = (state_q == ST_HALTED);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: a small instruction ROM answers inst_address combinationally.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic [31:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic        garbage;

    int checks;
    int errors;

    instruction_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .inst_address (inst_address),
        .read_data    (read_data),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_valid  (if_id_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word n holds 0x1000_0000+n, word 9 holds the halt encoding; garbage models
    // an unreliable memory on cycles where the fetch must not capture.
    always_comb begin
        if (garbage)
            read_data = 32'hDEAD_BEEF;
        else if (inst_address[7:0] == 8'd9)
            read_data = 32'hFFFF_FFFF;
        else
            read_data = 32'h1000_0000 + {24'd0, inst_address[7:0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_if(input string tag, input logic [15:0] pc, input logic [31:0] instr,
                            input logic valid, input logic [15:0] cnt, input logic [15:0] addr);
        check({tag, ".if_id_pc"}, 32'(if_id_pc), 32'(pc));
        check({tag, ".if_id_instr"}, if_id_instr, instr);
        check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(valid));
        check({tag, ".fetch_count"}, 32'(fetch_count), 32'(cnt));
        check({tag, ".inst_address"}, 32'(inst_address), 32'(addr));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        garbage       = 1'b0;

        #2;
        check_if("reset", 16'h0000, 32'h0, 1'b0, 16'd0, 16'h0001);
        check("reset.halted", 32'(halted), 32'h0);
        step();
        step();
        rst = 1'b0;

        step();
        check_if("idle", 16'h0000, 32'h0, 1'b0, 16'd0, 16'h0001);

        for (int i = 1; i <= 4; i++) begin
            step();
            check_if($sformatf("run%0d", i), 16'(i), 32'h1000_0000 + 32'(i), 1'b1, 16'(i), 16'(i + 1));
        end

        stall   = 1'b1;
        garbage = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_if($sformatf("stall%0d", i), 16'h0004, 32'h1000_0004, 1'b1, 16'd4, 16'h0005);
        end
        stall   = 1'b0;
        garbage = 1'b0;
        step();
        check_if("after_stall", 16'h0005, 32'h1000_0005, 1'b1, 16'd5, 16'h0006);
        step();
        check_if("run6", 16'h0006, 32'h1000_0006, 1'b1, 16'd6, 16'h0007);

        branch_taken  = 1'b1;
        branch_target = 16'h0120;
        stall         = 1'b1;
        flush         = 1'b1;
        garbage       = 1'b1;
        step();
        check_if("branch", 16'h0006, 32'h0, 1'b0, 16'd6, 16'h0020);
        branch_taken = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        garbage      = 1'b0;
        step();
        check_if("branch_tgt", 16'h0020, 32'h1000_0020, 1'b1, 16'd7, 16'h0021);

        branch_taken  = 1'b1;
        branch_target = 16'h00FF;
        step();
        check_if("to_ff", 16'h0020, 32'h0, 1'b0, 16'd7, 16'h00FF);
        branch_taken = 1'b0;
        step();
        check_if("wrap", 16'h00FF, 32'h1000_00FF, 1'b1, 16'd8, 16'h0000);

        flush   = 1'b1;
        garbage = 1'b1;
        step();
        check_if("flush0", 16'h00FF, 32'h0, 1'b0, 16'd8, 16'h0000);
        flush   = 1'b0;
        garbage = 1'b0;

        for (int k = 1; k <= 9; k++) step();
        check_if("pre_halt", 16'h0008, 32'h1000_0008, 1'b1, 16'd17, 16'h0009);

        step();
        check_if("halt_cap", 16'h0009, 32'hFFFF_FFFF, 1'b1, 16'd18, 16'h0009);

        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        step();
        check_if("halted1", 16'h0009, 32'hFFFF_FFFF, 1'b0, 16'd18, 16'h0009);
        check("halted1.halted", 32'(halted), 32'h1);
        flush = 1'b1;
        step();
        check_if("halted2", 16'h0009, 32'hFFFF_FFFF, 1'b0, 16'd18, 16'h0009);
        check("halted2.halted", 32'(halted), 32'h1);
        branch_taken = 1'b0;
        flush        = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check_if("re_idle", 16'h0000, 32'h0, 1'b0, 16'd0, 16'h0001);
        check("re_idle.halted", 32'(halted), 32'h0);
        step();
        check_if("re_run1", 16'h0001, 32'h1000_0001, 1'b1, 16'd1, 16'h0002);
        branch_taken  = 1'b1;
        branch_target = 16'h0030;
        step();
        branch_taken = 1'b0;
        check_if("at30", 16'h0001, 32'h0, 1'b0, 16'd1, 16'h0030);
        step();
        check_if("run30", 16'h0030, 32'h1000_0030, 1'b1, 16'd2, 16'h0031);

        #2;
        rst = 1'b1;
        #1;
        check_if("async_rst", 16'h0000, 32'h0, 1'b0, 16'd0, 16'h0001);
        check("async_rst.halted", 32'(halted), 32'h0);
        step();
        rst = 1'b0;
        step();
        check_if("post_idle", 16'h0000, 32'h0, 1'b0, 16'd0, 16'h0001);
        step();
        check_if("post_run1", 16'h0001, 32'h1000_0001, 1'b1, 16'd1, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
